calc_cordic: RTL and testbench
==============================

# calc_cordic

Iterative multi-function CORDIC engine in Q16.16 signed fixed point. It computes sin, cos, multiply, divide, sinh and cosh on one shared shift-add datapath, one micro-rotation per clock. It is the arithmetic core of the calculator datapath: a controller loads operands, pulses `enable`, waits for `done`, then reads `result`.

## Interface
- `WIDTH`, 32: datapath and port width. Q16.16 at 32; the fraction stays 16 bits for any WIDTH.
- `ITERATIONS`, 16: base micro-rotation count N.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `enable` in 1: start request, sampled on the rising edge.
- `operation` in 3: 0 SIN, 1 COS, 2 MULT, 3 DIV, 4 SINH, 5 COSH; 6 and 7 reserved.
- `x_in` in WIDTH: signed Q16.16 operand.
- `y_in` in WIDTH: signed Q16.16 operand.
- `z_in` in WIDTH: signed Q16.16 operand.
- `result` out WIDTH: signed Q16.16 result.
- `done` out 1: result valid (level).

## Operation
- Registers are signed WIDTH-bit x, y, z plus an iteration index.
- Shifts are arithmetic right shifts. Add/sub wraps at WIDTH bits with no saturation.
- **SIN/COS** (circular rotation). x_in and y_in are ignored.
  - Init: x = K = 39797 (0.607253), y = 0, z = z_in in radians.
  - For i = 0..N-1: d = +1 if z ≥ 0, else −1; x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atan(2^-i).
  - SIN returns y; COS returns x.
  - Valid range: |z_in| ≤ π/2.
- **MULT** (linear rotation).
  - Init: x = x_in, y = 0, z = z_in.
  - For i = 0..N-1: x is unchanged; y' = y + d·(x>>>i); z' = z − d·2^-i.
  - Returns y = x_in·z_in. Valid for |z_in| < 2.
- **DIV** (linear vectoring).
  - Init: x = x_in, y = y_in, z = 0.
  - For i = 0..N-1: d = +1 if y < 0, else −1; y' = y + d·(x>>>i); z' = z − d·2^-i.
  - Returns z = y_in/x_in. Valid for x_in > 0 and |y_in/x_in| < 2. x_in = 0 gives an unspecified value but still completes with the normal latency.
- **SINH/COSH** (hyperbolic rotation).
  - Init: x = x_in, y = 0, z = z_in. The caller supplies the gain correction in x_in (1.2075 → unit gain).
  - Index sequence is 1..N with indices 4 and 13 executed twice: N+2 steps.
  - Each step: x' = x + d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atanh(2^-i); d = sign(z) as in circular mode.
  - SINH returns y; COSH returns x. Valid for |z_in| ≤ 1.1.
- **Reserved opcodes**: result = 0; done asserts one edge after acceptance.
- Angle constants are round-to-nearest Q16.16 values of atan(2^-i) and atanh(2^-i).

## Timing
- FSM states: IDLE, RUN, DONE.
- Reset (async, `rst` low): state IDLE, `result` = 0, `done` = 0, all internal registers 0. Reset mid-RUN aborts the computation immediately.
- **Accept edge**: `enable` = 1 on a rising edge while in IDLE or DONE.
  - Samples `operation`, x_in, y_in and z_in into the registers.
  - Clears `done` and enters RUN.
  - Inputs are don't-care afterwards.
- **RUN**: one micro-rotation per edge.
  - `enable` is ignored.
  - On the edge executing the final step, `result` is loaded and `done` = 1, entering DONE.
- **Latency** from the accept edge to `done` high: N edges for circular and linear modes (16 at default), N+2 edges for hyperbolic modes (18).
- **DONE**: `done` and `result` hold until the next accept edge or reset. `enable` held high re-accepts on every DONE edge.

## Configuration
- `CALC_CORDIC_QUAD_EN` defined: SIN/COS add pre-rotation.
  - If z_in > π/2, use z − π; if z_in < −π/2, use z + π. In either case both outputs are negated.
  - Valid range extends to |z_in| ≤ π.
  - No latency change.
- Not defined: no pre-rotation; the range is |z_in| ≤ π/2 and behaviour outside it is unspecified.

## Structure
- Package `calc_cordic_pkg` holds:
  - opcode localparams;
  - FSM state encoding;
  - K and π, π/2 in Q16.16;
  - the atan table (entries 0..31) and the atanh table (entries 1..31).
- One sub-module `calc_cordic_rom`: combinational, index and mode in, Q16.16 angle out.
- The FSM and datapath live in the top module.

## Test plan
- SIN, z_in = 0.7854 → result 0.7071 ±0.001; COS with the same input → 0.7071 ±0.001. `done` rises exactly 16 edges after the accept edge.
- MULT, x_in = 1.5, z_in = 2.0 → 3.0 ±0.001.
- DIV, x_in = 9.0, y_in = 15.0 → 1.6667 ±0.001.
- SINH, x_in = 1.2075, z_in = 1.0 → 1.1752 ±0.002; COSH → 1.5431 ±0.002. `done` rises at 18 edges.
- `rst` asserted mid-RUN → `done` = 0 and `result` = 0 immediately. A following SIN run completes normally. `done` stays high until the next accept, and clears on that accept edge.
- With `CALC_CORDIC_QUAD_EN`: SIN z_in = 2.5 → 0.5985 ±0.002; COS z_in = −2.5 → −0.8011 ±0.002.

Source files
------------

// File: rtl/calc_cordic_pkg.sv
// Shared constants for the calc_cordic engine: opcodes, FSM/mode encodings,
// Q16.16 constants and the atan/atanh angle tables.
package calc_cordic_pkg;

    localparam logic [2:0] OP_SIN  = 3'd0;
    localparam logic [2:0] OP_COS  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SINH = 3'd4;
    localparam logic [2:0] OP_COSH = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_CIRC = 2'd0,
        MODE_LIN  = 2'd1,
        MODE_HYP  = 2'd2,
        MODE_NONE = 2'd3
    } mode_e;

    localparam logic signed [31:0] CORDIC_K  = 32'sd39797;
    localparam logic signed [31:0] Q_PI      = 32'sd205887;
    localparam logic signed [31:0] Q_HALF_PI = 32'sd102944;

    function automatic mode_e op_mode(input logic [2:0] op);
        case (op)
            OP_SIN, OP_COS:   return MODE_CIRC;
            OP_MULT, OP_DIV:  return MODE_LIN;
            OP_SINH, OP_COSH: return MODE_HYP;
            default:          return MODE_NONE;
        endcase
    endfunction

    // Hyperbolic shift sequence 1,2,3,4,4,5..13,13,14.. indexed by step count.
    function automatic logic [4:0] hyp_index(input logic [5:0] step);
        if (step < 6'd4)
            return 5'(step + 6'd1);
        else if (step < 6'd14)
            return 5'(step);
        else
            return 5'(step - 6'd1);
    endfunction

    function automatic logic [31:0] atan_q16(input logic [4:0] i);
        case (i)
            5'd0:    return 32'd51472;
            5'd1:    return 32'd30386;
            5'd2:    return 32'd16055;
            5'd3:    return 32'd8150;
            5'd4:    return 32'd4091;
            5'd5:    return 32'd2047;
            5'd6:    return 32'd1024;
            5'd7:    return 32'd512;
            5'd8:    return 32'd256;
            5'd9:    return 32'd128;
            5'd10:   return 32'd64;
            5'd11:   return 32'd32;
            5'd12:   return 32'd16;
            5'd13:   return 32'd8;
            5'd14:   return 32'd4;
            5'd15:   return 32'd2;
            5'd16:   return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    // Entry 17 rounds up because atanh(x) is slightly above x.
    function automatic logic [31:0] atanh_q16(input logic [4:0] i);
        case (i)
            5'd1:    return 32'd35999;
            5'd2:    return 32'd16739;
            5'd3:    return 32'd8235;
            5'd4:    return 32'd4101;
            5'd5:    return 32'd2049;
            5'd6:    return 32'd1024;
            5'd7:    return 32'd512;
            5'd8:    return 32'd256;
            5'd9:    return 32'd128;
            5'd10:   return 32'd64;
            5'd11:   return 32'd32;
            5'd12:   return 32'd16;
            5'd13:   return 32'd8;
            5'd14:   return 32'd4;
            5'd15:   return 32'd2;
            5'd16:   return 32'd1;
            5'd17:   return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/calc_cordic_rom.sv
// Combinational angle lookup: atan, 2^-i or atanh in Q16.16 for the current
// micro-rotation index and CORDIC mode.
module calc_cordic_rom import calc_cordic_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       idx_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] angle_o
);

    logic [31:0] raw;

    always_comb begin
        raw = '0;
        case (mode_i)
            MODE_CIRC: raw = atan_q16(idx_i);
            MODE_LIN:  raw = 32'h0001_0000 >> idx_i;
            MODE_HYP:  raw = atanh_q16(idx_i);
            default:   raw = '0;
        endcase
    end

    assign angle_o = WIDTH'(raw);

endmodule

// File: rtl/calc_cordic.sv
// Iterative multi-function CORDIC (sin/cos/mult/div/sinh/cosh), Q16.16.
// Optional CALC_CORDIC_QUAD_EN adds a +/-pi pre-rotation for SIN/COS.
module calc_cordic import calc_cordic_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic [1:0]       dbg_state_o
);

    localparam logic signed [WIDTH-1:0] K_W = WIDTH'(CORDIC_K);
`ifdef CALC_CORDIC_QUAD_EN
    localparam logic signed [WIDTH-1:0] PI_W      = WIDTH'(Q_PI);
    localparam logic signed [WIDTH-1:0] HALF_PI_W = WIDTH'(Q_HALF_PI);
`endif

    state_e                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [5:0]              step_q, step_d;
    logic                    neg_q, neg_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic                    done_q, done_d;

    mode_e                   mode;
    logic [4:0]              idx;
    logic [5:0]              last_step;
    logic [WIDTH-1:0]        angle_raw;
    logic signed [WIDTH-1:0] angle, x_sh, y_sh, x_step, y_step, z_step, res_raw;
    logic                    dir_pos;

    assign mode      = op_mode(op_q);
    assign idx       = (mode == MODE_HYP) ? hyp_index(step_q) : step_q[4:0];
    assign last_step = (mode == MODE_HYP)  ? 6'(ITERATIONS + 1) :
                       (mode == MODE_NONE) ? 6'd0 : 6'(ITERATIONS - 1);

    calc_cordic_rom #(.WIDTH(WIDTH)) u_rom (
        .idx_i   (idx),
        .mode_i  (mode),
        .angle_o (angle_raw)
    );

    assign angle = angle_raw;

    // One micro-rotation; dir_pos means d = +1.
    always_comb begin
        x_sh    = x_q >>> idx;
        y_sh    = y_q >>> idx;
        dir_pos = (op_q == OP_DIV) ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
        case (mode)
            MODE_CIRC: x_step = dir_pos ? x_q - y_sh : x_q + y_sh;
            MODE_HYP:  x_step = dir_pos ? x_q + y_sh : x_q - y_sh;
            default:   x_step = x_q;
        endcase
        y_step = dir_pos ? y_q + x_sh : y_q - x_sh;
        z_step = dir_pos ? z_q - angle : z_q + angle;
        case (op_q)
            OP_SIN, OP_SINH, OP_MULT: res_raw = y_step;
            OP_COS, OP_COSH:          res_raw = x_step;
            OP_DIV:                   res_raw = z_step;
            default:                  res_raw = '0;
        endcase
        if (neg_q)
            res_raw = -res_raw;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        step_d   = step_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    op_d    = operation;
                    step_d  = '0;
                    done_d  = 1'b0;
                    neg_d   = 1'b0;
                    x_d     = x_in;
                    y_d     = '0;
                    z_d     = z_in;
                    case (operation)
                        OP_SIN, OP_COS: begin
                            x_d = K_W;
`ifdef CALC_CORDIC_QUAD_EN
                            if ($signed(z_in) > HALF_PI_W) begin
                                z_d   = $signed(z_in) - PI_W;
                                neg_d = 1'b1;
                            end else if ($signed(z_in) < -HALF_PI_W) begin
                                z_d   = $signed(z_in) + PI_W;
                                neg_d = 1'b1;
                            end
`else
                            neg_d = 1'b0;
`endif
                        end
                        OP_DIV: begin
                            y_d = y_in;
                            z_d = '0;
                        end
                        OP_MULT, OP_SINH, OP_COSH: ;
                        default: begin
                            x_d = '0;
                            z_d = '0;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                x_d    = x_step;
                y_d    = y_step;
                z_d    = z_step;
                step_d = step_q + 6'd1;
                if (step_q == last_step) begin
                    state_d  = ST_DONE;
                    result_d = res_raw;
                    done_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            step_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            step_q   <= step_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result      = result_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_calc_cordic.sv
// Self-checking bench for calc_cordic; the quadrant vectors run only when
// CALC_CORDIC_QUAD_EN is defined.
module tb_calc_cordic;

    localparam int W = 32;
    localparam logic [2:0] T_SIN  = 3'd0;
    localparam logic [2:0] T_COS  = 3'd1;
    localparam logic [2:0] T_MULT = 3'd2;
    localparam logic [2:0] T_DIV  = 3'd3;
    localparam logic [2:0] T_SINH = 3'd4;
    localparam logic [2:0] T_COSH = 3'd5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [2:0]   operation = '0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic [W-1:0] z_in = '0;
    logic [W-1:0] result;
    logic         done;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic done_prev = 1'b0;

    logic [W-1:0] exp_q[$];
    int           tol_q[$];
    int           lat_q[$];
    int           acc_q[$];
    string        name_q[$];

    calc_cordic #(.WIDTH(W), .ITERATIONS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .operation   (operation),
        .x_in        (x_in),
        .y_in        (y_in),
        .z_in        (z_in),
        .result      (result),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic signed [W-1:0] act,
                         input logic signed [W-1:0] exp, input int tol);
        int diff;
        total++;
        diff = int'(act) - int'(exp);
        if (diff < 0)
            diff = -diff;
        if (diff > tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    // Scoreboard monitor: every rising done pops one expectation.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 want no pending op");
            end else begin
                logic [W-1:0] e;
                int t, l, a;
                string nm;
                e  = exp_q.pop_front();
                t  = tol_q.pop_front();
                l  = lat_q.pop_front();
                a  = acc_q.pop_front();
                nm = name_q.pop_front();
                check(nm, result, e, t);
                check({nm, "_lat"}, cyc - a, l, 0);
            end
        end
        done_prev = done;
    end

    task automatic start_op(input logic [2:0] op, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] z);
        @(negedge clk);
        operation = op;
        x_in      = x;
        y_in      = y;
        z_in      = z;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        enable    = 1'b0;
        operation = 3'($urandom_range(0, 7));
        x_in      = $urandom;
        y_in      = $urandom;
        z_in      = $urandom;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_finished"}, done, 1, 0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] z, input logic [W-1:0] e, input int tol,
                          input int lat, input string nm);
        start_op(op, x, y, z);
        exp_q.push_back(e);
        tol_q.push_back(tol);
        lat_q.push_back(lat);
        acc_q.push_back(cyc);
        name_q.push_back(nm);
        check({nm, "_accept_clr"}, done, 0, 0);
        wait_done(nm);
    endtask

    initial begin
        #2 rst = 1'b0;
        #20;
        check("rst_done", done, 0, 0);
        check("rst_result", result, 0, 0);
        check("rst_state", dbg_state, 0, 0);
        @(negedge clk) rst = 1'b1;

        run_op(T_SIN,  0, 0, 51472, 46341, 66, 16, "sin_pi4");
        run_op(T_COS,  0, 0, 51472, 46341, 66, 16, "cos_pi4");
        run_op(T_SIN,  0, 0, -34315, -32768, 66, 16, "sin_neg_pi6");
        run_op(T_MULT, 98304, 0, 131072, 196608, 66, 16, "mult_1p5x2");
        run_op(T_MULT, -147456, 0, 32768, -73728, 66, 16, "mult_neg");
        run_op(T_DIV,  589824, 983040, 0, 109227, 66, 16, "div_15_9");
        run_op(T_SINH, 79135, 0, 65536, 77018, 131, 18, "sinh_1");
        run_op(T_COSH, 79135, 0, 65536, 101128, 131, 18, "cosh_1");
        run_op(3'd6, 98304, 98304, 98304, 0, 0, 1, "reserved6");
        run_op(3'd7, 98304, 98304, 98304, 0, 0, 1, "reserved7");

        run_op(T_MULT, 98304, 0, 131072, 196608, 66, 16, "mult_again");
        repeat (6) @(negedge clk);
        check("hold_done", done, 1, 0);
        check("hold_result", result, 196608, 66);

        start_op(T_SIN, 0, 0, 51472);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("abort_done", done, 0, 0);
        check("abort_result", result, 0, 0);
        check("abort_state", dbg_state, 0, 0);
        @(negedge clk) rst = 1'b1;

        run_op(T_SIN, 0, 0, 51472, 46341, 66, 16, "sin_after_rst");
`ifdef CALC_CORDIC_QUAD_EN
        run_op(T_SIN, 0, 0, 163840, 39222, 131, 16, "quad_sin_2p5");
        run_op(T_COS, 0, 0, -163840, -52504, 131, 16, "quad_cos_m2p5");
`endif

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
